// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    HUNT  = 2'd1,
    MATCH = 2'd2
  } state_t;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/match_counter.sv
// Saturating match counter; a clear always beats an increment in the same cycle.
module match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, hold at all-ones, drop to zero on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-loadable serial pattern detector with overlap control and a
// saturating match counter. The match flag is a pure decode of the state
// register, so no input reaches it combinationally.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_val,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             i,
  input  logic             i_valid,
  input  logic             cnt_clr,
  output logic             o,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  state_t           state;
  state_t           state_next;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_next;
  logic             load_ok;
  logic             accept;
  logic             hit;

  // Qualify loads and samples, build the shifted history and length mask,
  // and decide whether the incoming sample completes the pattern.
  always_comb begin
    load_ok   = pat_load && (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));
    accept    = i_valid && !pat_load && (state != UNCFG);
    hist_next = (hist << 1) | PAT_W'(i);
    fill_next = (fill < len) ? fill + LEN_W'(1) : len;
    mask      = '0;
    for (int b = 0; b < PAT_W; b++) begin
      mask[b] = (b < int'(len));
    end
    hit = accept && (fill_next == len) && (((hist_next ^ pat) & mask) == '0);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNCFG;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a legal load restarts the hunt from any state; otherwise only
  // an accepted sample moves the machine, so idle cycles hold MATCH.
  always_comb begin
    state_next = state;
    if (load_ok) begin
      state_next = HUNT;
    end else if (accept) begin
      state_next = hit ? MATCH : HUNT;
    end
  end

  // Pattern, history and fill tracking plus the one-cycle config error pulse.
  // A non-overlapping match empties the fill so the next match needs a full
  // fresh pattern's worth of samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat     <= '0;
      len     <= '0;
      hist    <= '0;
      fill    <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= pat_load && !load_ok;
      if (load_ok) begin
        pat  <= pat_val;
        len  <= pat_len;
        hist <= '0;
        fill <= '0;
      end else if (accept) begin
        hist <= hist_next;
        fill <= (hit && !overlap) ? '0 : fill_next;
      end
    end
  end

  assign o = (state == MATCH);

  match_counter #(
    .CNT_W(CNT_W)
  ) u_match_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit),
    .clr  (cnt_clr),
    .count(match_cnt)
  );

endmodule

// File: doc/param_seq_detector.md
# param_seq_detector

Parametrised Moore-style serial pattern detector: a runtime-loadable bit pattern of 1..PAT_W bits is matched against a qualified serial input stream. Overlapping and non-overlapping match modes are supported, and a saturating match counter is maintained. It sits in the serial-input path as the generalised successor to the team's fixed-pattern detectors, and is intended for framing, sync-word and marker detection.

## Interface
- PAT_W, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- LEN_W, $clog2(PAT_W)+1: pattern-length field width (derived; do not override).
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- pat_load  input  1  load pattern/length this cycle.
- pat_val  input  PAT_W  pattern; bit [len-1] is first-received bit, bit [0] last-received.
- pat_len  input  LEN_W  pattern length, legal 1..PAT_W.
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every accepted sample.
- i  input  1  serial data bit.
- i_valid  input  1  i is qualified this cycle.
- cnt_clr  input  1  synchronous clear of match_cnt.
- o  output  1  Moore match flag (registered).
- match_cnt  output  CNT_W  saturating count of matches.
- cfg_err  output  1  one-cycle pulse: illegal pat_len rejected.

## Operation
- States: UNCFG, HUNT, MATCH (enum in package).
- Reset: state UNCFG; pattern, length, history, fill counter, o, match_cnt, cfg_err all 0.
- UNCFG: i_valid ignored; o=0. Legal pat_load → HUNT.
- pat_load with pat_len in 1..PAT_W, from any state: capture pattern and length; clear history and fill; go to HUNT; o=0 next cycle.
- pat_load with pat_len 0 or >PAT_W: config, state and history unchanged; cfg_err=1 for one cycle.
- pat_load has priority over i_valid in the same cycle; that sample is discarded.
- Accepted sample (i_valid=1, no pat_load, state≠UNCFG): new history = {hist[PAT_W-2:0], i}; fill = min(fill+1, pat_len).
- Match: new fill == pat_len and new history[len-1:0] == pattern[len-1:0] → next state MATCH, match_cnt +1; otherwise → HUNT.
- After a match: overlap=1 keeps history and fill (for example, 1101 in 1101101 gives 2 matches). overlap=0 clears fill to 0, so the next match needs pat_len fresh samples (1101101 gives 1 match).
- MATCH is held until the next accepted sample; cycles without i_valid do not change the state.
- o = (state == MATCH), with no combinational path from inputs.
- match_cnt saturates at 2^CNT_W-1.
- cnt_clr wins over a simultaneous increment: result 0, but o still asserts for that match.

## Timing
- Match latency: sample accepted at edge k → o high after edge k, low after the next accepted sample's edge (or after a pat_load edge).
- match_cnt updates on the same edge as o rises.
- cfg_err is high for exactly the cycle after the illegal load edge.
- rst asserted mid-stream: all outputs 0 immediately (asynchronous); block returns to UNCFG and needs a new pat_load.
- Back-to-back i_valid: one sample per clock, no bubbles required.

## Structure
- Package seq_det_pkg:
  - state_t enum {UNCFG, HUNT, MATCH}.
  - Default-parameter constants.
- Sub-module match_counter: parameter CNT_W; inputs clk, rst, inc, clr; output count.
  - Saturating.
  - clr has priority over inc.
- Top module: FSM, history shift register, fill counter, masked compare.

## Test plan
- Reset then 1101101 with PAT_W=8, pat_len=4, pat_val=8'h0D, overlap=1 → o high after the 4th and 7th samples, each for one sample period; match_cnt=2.
- Same stream with overlap=0 → single match after the 4th sample; match_cnt=1.
- i_valid gaps: 1,1,(idle 3 cycles),0,1 → match after the final 1; o stays high through a following 2-cycle i_valid gap.
- pat_len=0 and pat_len=9 loads → cfg_err pulse each time; prior pattern still detects; load plus i_valid in the same cycle → sample discarded.
- CNT_W=2, 5 matches → match_cnt saturates at 3; cnt_clr coincident with a match → match_cnt=0 and o=1.
- Assert rst mid-match while o=1 → o and match_cnt 0 immediately; samples ignored until pat_load; pat_len=1, pat_val=1 → o follows each accepted 1.
